resp_encoder: RTL and testbench

RESP_ENCODER -- requirements
Module: resp_encoder

---
 rtl/cmd_pkg.sv | 27 ++
 rtl/resp_encoder.sv | 118 +++++++++++
 tb/tb_resp_encoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared command/response packet types and encoder states
//
// Provides:
//   cmd_packet_t      24-bit packet {opcode, addr, data}
//   SOF_DEFAULT       default start-of-frame marker for response frames
//   resp_enc_state_t  resp_encoder FSM states
package cmd_pkg;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_packet_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_OPC  = 3'd2,
        ST_ADDR = 3'd3,
        ST_DATA = 3'd4,
        ST_CSUM = 3'd5,
        ST_GAP  = 3'd6
    } resp_enc_state_t;

endpackage

// File: rtl/resp_encoder.sv
// rtl/resp_encoder.sv - serialises response packets into 5-byte UART frames
//
// Frame: SOF_BYTE, opcode, addr, data, csum (opcode ^ addr ^ data), followed
// by GAP_CYCLES idle clocks before the encoder accepts another packet.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   resp_pkt      packet from resp_fifo (sampled only on acceptance)
//   resp_valid    resp_pkt holds a packet
//   resp_ready    encoder accepts resp_pkt this cycle (IDLE only)
//   tx_byte       byte towards uart_tx
//   tx_valid      tx_byte is valid
//   tx_ready      uart_tx takes tx_byte this cycle
//   busy          frame in progress or gap counting
//   frame_cnt     completed frames, wraps at 16 bits
module resp_encoder
    import cmd_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE   = SOF_DEFAULT,
    parameter int         GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  cmd_packet_t resp_pkt,
    input  logic        resp_valid,
    output logic        resp_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    // Keep the counter at least one bit wide so GAP_CYCLES=0 still elaborates.
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    resp_enc_state_t state_q;
    cmd_packet_t     pkt_q;
    logic [7:0]      csum_q;
    logic [GW-1:0]   gap_cnt_q;
    // Holds resp_ready low until the first clock after reset release.
    logic            ready_en_q;

    logic       accept;
    logic       xfer;
    logic [7:0] csum_in;

    assign csum_in    = resp_pkt.opcode ^ resp_pkt.addr ^ resp_pkt.data;
    assign resp_ready = (state_q == ST_IDLE) && ready_en_q;
    assign accept     = resp_valid && resp_ready;
    assign tx_valid   = (state_q == ST_SOF) || (state_q == ST_OPC) || (state_q == ST_ADDR)
                     || (state_q == ST_DATA) || (state_q == ST_CSUM);
    // tx_ready outside a byte state is ignored because xfer requires tx_valid.
    assign xfer       = tx_valid && tx_ready;
    assign busy       = (state_q != ST_IDLE);

    // The byte is a pure function of state and the registered packet, so it
    // stays stable for as long as uart_tx stalls.
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            ST_SOF:  tx_byte = SOF_BYTE;
            ST_OPC:  tx_byte = pkt_q.opcode;
            ST_ADDR: tx_byte = pkt_q.addr;
            ST_DATA: tx_byte = pkt_q.data;
            ST_CSUM: tx_byte = csum_q;
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pkt_q      <= '0;
            csum_q     <= 8'h00;
            gap_cnt_q  <= '0;
            frame_cnt  <= 16'h0000;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        pkt_q   <= resp_pkt;
                        csum_q  <= csum_in;
                        state_q <= ST_SOF;
                    end
                end
                ST_SOF:  if (xfer) state_q <= ST_OPC;
                ST_OPC:  if (xfer) state_q <= ST_ADDR;
                ST_ADDR: if (xfer) state_q <= ST_DATA;
                ST_DATA: if (xfer) state_q <= ST_CSUM;
                ST_CSUM: begin
                    if (xfer) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        gap_cnt_q <= '0;
                        if (GAP_CYCLES > 0) begin
                            state_q <= ST_GAP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resp_encoder.sv
// tb/tb_resp_encoder.sv - self-checking bench for resp_encoder
module tb_resp_encoder;
    import cmd_pkg::*;

    localparam int GAP = 16;

    logic        clk;
    logic        rst_n;
    cmd_packet_t resp_pkt;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic [15:0] frame_cnt;

    cmd_packet_t resp_pkt0;
    logic        resp_valid0;
    logic        resp_ready0;
    logic [7:0]  tx_byte0;
    logic        tx_valid0;
    logic        tx_ready0;
    logic        busy0;
    logic [15:0] frame_cnt0;

    resp_encoder #(.SOF_BYTE(8'hA5), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .resp_pkt(resp_pkt), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .tx_byte(tx_byte), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_cnt(frame_cnt)
    );

    resp_encoder #(.SOF_BYTE(8'hA5), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .resp_pkt(resp_pkt0), .resp_valid(resp_valid0),
        .resp_ready(resp_ready0), .tx_byte(tx_byte0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .busy(busy0), .frame_cnt(frame_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors;
    int          miscompares;
    logic [15:0] exp_fc;

    typedef struct {
        logic [7:0] op;
        logic [7:0] ad;
        logic [7:0] da;
        logic [7:0] csum;
        int         stall_at;
        int         stall_len;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!resp_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(name, (t < 200), 1);
    endtask

    // Sends one packet through dut with tx_ready high except for an optional
    // stall of stall_len clocks on byte index stall_at; checks every byte.
    task automatic send(input logic [7:0] op, ad, da, csum, input int stall_at, stall_len);
        logic [7:0] e [5];
        logic [7:0] h;
        e[0] = 8'hA5; e[1] = op; e[2] = ad; e[3] = da; e[4] = csum;
        wait_ready("ready_wait");
        resp_pkt   = {op, ad, da};
        resp_valid = 1'b1;
        tx_ready   = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_pkt   = cmd_packet_t'($urandom);
        for (int i = 0; i < 5; i++) begin
            if (i == stall_at) begin
                tx_ready = 1'b0;
                h = tx_byte;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    chk("stall_valid", tx_valid, 1);
                    chk("stall_byte", tx_byte, h);
                end
                tx_ready = 1'b1;
            end
            chk("byte_valid", tx_valid, 1);
            chk("byte_value", tx_byte, e[i]);
            chk("busy_frame", busy, 1);
            @(negedge clk);
        end
        exp_fc = exp_fc + 16'd1;
        chk("frame_cnt", frame_cnt, exp_fc);
        chk("gap_valid", tx_valid, 0);
        chk("gap_busy", busy, 1);
    endtask

    logic [7:0] mq [$];
    int         gap_left;
    logic       exp_rdy;
    int         gapn;
    cmd_packet_t pa, pb;

    initial begin
        vectors = 0; miscompares = 0; exp_fc = 16'h0;
        rst_n = 1'b0; resp_valid = 1'b0; resp_pkt = '0; tx_ready = 1'b0;
        resp_valid0 = 1'b0; resp_pkt0 = '0; tx_ready0 = 1'b0;

        tbl[0] = '{8'h52, 8'h10, 8'h3C, 8'h7E, -1, 0};
        tbl[1] = '{8'h52, 8'h10, 8'h3C, 8'h7E,  2, 7};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 8'h00,  0, 3};
        tbl[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00,  4, 1};
        tbl[4] = '{8'h12, 8'h34, 8'h56, 8'h70,  1, 2};
        tbl[5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD0, -1, 0};

        // Reset values, with tx_ready asserted to show it is ignored while idle.
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", tx_valid, 0);
        chk("rst_byte", tx_byte, 8'h00);
        chk("rst_ready", resp_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fcnt", frame_cnt, 16'h0);
        rst_n = 1'b1;
        #1 chk("ready_before_clk", resp_ready, 0);
        @(negedge clk);
        chk("ready_after_clk", resp_ready, 1);
        chk("idle_valid", tx_valid, 0);

        for (int v = 0; v < 6; v++) begin
            send(tbl[v].op, tbl[v].ad, tbl[v].da, tbl[v].csum, tbl[v].stall_at, tbl[v].stall_len);
        end

        // Back-to-back: resp_valid held high, packet swapped after acceptance.
        pa = {8'h52, 8'h10, 8'h3C};
        pb = {8'h11, 8'h22, 8'h44};
        wait_ready("b2b_ready");
        resp_pkt = pa; resp_valid = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        resp_pkt = pb;
        chk("b2b_sof", tx_byte, 8'hA5);
        repeat (4) @(negedge clk);
        chk("b2b_csum", tx_byte, 8'h7E);
        @(negedge clk);
        gapn = 0;
        while (!tx_valid && gapn < 100) begin
            gapn++;
            @(negedge clk);
        end
        resp_valid = 1'b0;
        // GAP clocks plus the IDLE clock in which the next packet is accepted.
        chk("b2b_gap_len", gapn, GAP + 1);
        chk("b2b_sof2", tx_byte, 8'hA5);
        @(negedge clk); chk("b2b_opc2", tx_byte, 8'h11);
        @(negedge clk); chk("b2b_adr2", tx_byte, 8'h22);
        @(negedge clk); chk("b2b_dat2", tx_byte, 8'h44);
        @(negedge clk); chk("b2b_csm2", tx_byte, 8'h77);
        @(negedge clk);
        exp_fc = exp_fc + 16'd2;
        chk("b2b_fcnt", frame_cnt, exp_fc);

        // Reset during the DATA byte.
        wait_ready("rstmid_ready");
        resp_pkt = {8'h52, 8'h10, 8'h3C}; resp_valid = 1'b1; tx_ready = 1'b1;
        @(negedge clk);
        resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_data", tx_byte, 8'h3C);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", tx_valid, 0);
        chk("rstmid_fcnt", frame_cnt, 16'h0);
        chk("rstmid_byte", tx_byte, 8'h00);
        chk("rstmid_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_fc = 16'h0;
        @(negedge clk);
        chk("rstmid_idle_valid", tx_valid, 0);
        send(8'h52, 8'h10, 8'h3C, 8'h7E, -1, 0);

        // GAP_CYCLES=0 instance.
        begin
            logic [7:0] e0 [5];
            int t;
            e0[0] = 8'hA5; e0[1] = 8'h57; e0[2] = 8'hFF; e0[3] = 8'hFF; e0[4] = 8'h57;
            t = 0;
            while (!resp_ready0 && t < 50) begin @(negedge clk); t++; end
            chk("g0_ready_wait", (t < 50), 1);
            resp_pkt0 = {8'h57, 8'hFF, 8'hFF}; resp_valid0 = 1'b1; tx_ready0 = 1'b1;
            @(negedge clk);
            resp_valid0 = 1'b0;
            for (int i = 0; i < 5; i++) begin
                chk("g0_valid", tx_valid0, 1);
                chk("g0_byte", tx_byte0, e0[i]);
                @(negedge clk);
            end
            chk("g0_ready_after_csum", resp_ready0, 1);
            chk("g0_fcnt", frame_cnt0, 16'h1);
        end

        // Randomised traffic against a queue/countdown model.
        wait_ready("rnd_ready_wait");
        mq.delete();
        gap_left = 0;
        resp_valid = 1'b0;
        tx_ready = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            exp_rdy = (mq.size() == 0) && (gap_left == 0);
            chk("rnd_ready", resp_ready, exp_rdy);
            chk("rnd_valid", tx_valid, (mq.size() != 0));
            if (mq.size() != 0) chk("rnd_byte", tx_byte, mq[0]);
            chk("rnd_busy", busy, !exp_rdy);
            chk("rnd_fcnt", frame_cnt, exp_fc);
            tx_ready   = ($urandom_range(0, 9) < 7);
            resp_valid = ($urandom_range(0, 3) == 0);
            resp_pkt   = cmd_packet_t'($urandom);
            if (mq.size() != 0) begin
                if (tx_ready) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) begin
                        exp_fc = exp_fc + 16'd1;
                        gap_left = GAP;
                    end
                end
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (resp_valid) begin
                mq.push_back(8'hA5);
                mq.push_back(resp_pkt.opcode);
                mq.push_back(resp_pkt.addr);
                mq.push_back(resp_pkt.data);
                mq.push_back(resp_pkt.opcode ^ resp_pkt.addr ^ resp_pkt.data);
            end
        end
        resp_valid = 1'b0;
        tx_ready = 1'b1;
        @(negedge clk);

        // frame_cnt wrap from FFFF.
        wait_ready("wrap_ready");
        force dut.frame_cnt = 16'hFFFF;
        #1;
        release dut.frame_cnt;
        #1;
        chk("wrap_preload", frame_cnt, 16'hFFFF);
        exp_fc = 16'hFFFF;
        send(8'h01, 8'h02, 8'h04, 8'h07, -1, 0);
        chk("wrap_zero", frame_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
